// File: rtl/dvp_capture_ex.sv
// DVP sensor capture: registers the sensor pins, assembles BYTES_PER_PIX bytes per
// pixel and emits a sop/eop/vld framed stream with frame skip, decimation and geometry checks.
module dvp_capture_ex #(
  parameter int DIN_W         = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACT         = 1280,
  parameter int V_ACT         = 720,
  parameter int SKIP_FRAMES   = 10,
  parameter int VS_POL        = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [3:0]                     frame_decim,
  input  logic                           vsync,
  input  logic                           href,
  input  logic [DIN_W-1:0]               din,
  output logic [DIN_W*BYTES_PER_PIX-1:0] dout,
  output logic                           dout_sop,
  output logic                           dout_eop,
  output logic                           dout_vld,
  output logic                           frame_err,
  output logic [15:0]                    frame_cnt,
  output logic [1:0]                     dbg_state_o
);

  localparam int DOUT_W = DIN_W * BYTES_PER_PIX;
  localparam int XW     = $clog2(H_ACT + 1);
  localparam int YW     = $clog2(V_ACT + 1);
  localparam int BW     = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int SW     = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

  localparam logic [XW-1:0] X_FULL    = XW'(H_ACT);
  localparam logic [XW-1:0] X_LAST    = XW'(H_ACT - 1);
  localparam logic [YW-1:0] Y_FULL    = YW'(V_ACT);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_ACT - 1);
  localparam logic [BW-1:0] BC_LAST   = BW'(BYTES_PER_PIX - 1);
  localparam logic [SW-1:0] SKIP_INIT = SW'(SKIP_FRAMES);
  localparam logic          VS_ACT    = (VS_POL != 0);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_prev_q, href_q, href_prev_q;
  logic [DIN_W-1:0]    din_q;
  logic [SW-1:0]       skip_q, skip_d;
  logic [3:0]          dcnt_q, dcnt_d;
  logic [BW-1:0]       bc_q, bc_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [DOUT_W-1:0]   sh_q, sh_d, dout_q, dout_d, pix_next;
  logic                vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;
  logic [15:0]         fcnt_q, fcnt_d;
  logic                fs, h_rise, h_fall, start_eval, is_eop;

  assign fs       = (vs_q == VS_ACT) && (vs_prev_q != VS_ACT);
  assign h_rise   = href_q & ~href_prev_q;
  assign h_fall   = ~href_q & href_prev_q;
  assign pix_next = DOUT_W'({sh_q, din_q});
  assign is_eop   = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    dcnt_d     = dcnt_q;
    bc_d       = bc_q;
    x_d        = x_q;
    y_d        = y_q;
    sh_d       = sh_q;
    dout_d     = dout_q;
    vld_d      = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    fcnt_d     = fcnt_q;
    start_eval = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_VS;
          skip_d  = SKIP_INIT;
          dcnt_d  = 4'd0;
        end
      end
      WAIT_VS: start_eval = fs;
      ACTIVE: begin
        if (fs) begin
          // A new frame started before eop: flag it, then treat this edge as a normal start.
          err_d      = 1'b1;
          state_d    = WAIT_VS;
          start_eval = 1'b1;
        end else if (h_fall) begin
          if (x_q != X_FULL || bc_q != '0) begin
            err_d   = 1'b1;
            state_d = WAIT_VS;
            bc_d = '0; x_d = '0; y_d = '0;
          end else begin
            y_d  = y_q + 1'b1;
            x_d  = '0;
            bc_d = '0;
          end
        end else if (href_q) begin
          if ((h_rise && y_q == Y_FULL) || x_q == X_FULL) begin
            err_d   = 1'b1;
            state_d = WAIT_VS;
            bc_d = '0; x_d = '0; y_d = '0;
          end else begin
            sh_d = pix_next;
            if (bc_q == BC_LAST) begin
              bc_d   = '0;
              dout_d = pix_next;
              vld_d  = 1'b1;
              sop_d  = (x_q == '0) && (y_q == '0);
              eop_d  = is_eop;
              x_d    = x_q + 1'b1;
              if (is_eop) begin
                fcnt_d  = fcnt_q + 16'd1;
                state_d = enable ? WAIT_VS : IDLE;
                bc_d = '0; x_d = '0; y_d = '0;
              end
            end else begin
              bc_d = bc_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame-start decision shared by WAIT_VS and the restart path out of ACTIVE.
    if (start_eval) begin
      bc_d = '0; x_d = '0; y_d = '0;
      if (!enable) begin
        state_d = IDLE;
      end else if (skip_q != '0) begin
        skip_d  = skip_q - 1'b1;
        state_d = WAIT_VS;
      end else begin
        dcnt_d  = (dcnt_q >= frame_decim) ? 4'd0 : dcnt_q + 4'd1;
        state_d = (dcnt_q == 4'd0) ? ACTIVE : WAIT_VS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vs_q        <= ~VS_ACT;
      vs_prev_q   <= ~VS_ACT;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      din_q       <= '0;
      skip_q      <= SKIP_INIT;
      dcnt_q      <= 4'd0;
      bc_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      sh_q        <= '0;
      dout_q      <= '0;
      vld_q       <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
      fcnt_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vsync;
      vs_prev_q   <= vs_q;
      href_q      <= href;
      href_prev_q <= href_q;
      din_q       <= din;
      skip_q      <= skip_d;
      dcnt_q      <= dcnt_d;
      bc_q        <= bc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sh_q        <= sh_d;
      dout_q      <= dout_d;
      vld_q       <= vld_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      err_q       <= err_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign dout        = dout_q;
  assign dout_vld    = vld_q;
  assign dout_sop    = sop_q;
  assign dout_eop    = eop_q;
  assign frame_err   = err_q;
  assign frame_cnt   = fcnt_q;
  assign dbg_state_o = state_q;

endmodule
